// File: rtl/sha256_search_host_if_if.sv
// ---------------------------------------------------------------------------
// sha256_search_host_if_if
//   8-bit AXI-Stream style byte channel used on both host-facing sides of
//   sha256_search_host_if.
//
//   Signals:
//     tdata   8-bit payload byte
//     tvalid  producer has a byte
//     tlast   byte closes the frame
//     tready  consumer takes the byte (transfer on tvalid && tready)
//
//   Modports:
//     master  producer view (drives tdata/tvalid/tlast, samples tready)
//     slave   consumer view (samples tdata/tvalid/tlast, drives tready)
// ---------------------------------------------------------------------------
interface sha256_search_host_if_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sha256_search_host_if.sv
// ---------------------------------------------------------------------------
// sha256_search_host_if
//   Host-side initiator for the brute-force SHA-256 search manager.
//   Collects a 32-byte target hash from the host stream, starts the manager,
//   waits for its finish and returns a status/result frame to the host.
//
//   Build option:
//     SEARCH_TIMEOUT_EN  when defined, a search that sees no finish within
//                        TIMEOUT_CYCLES cycles is aborted with a one-cycle
//                        core_resetn pulse and answered with status 8'h02.
//                        When undefined, the search waits indefinitely and
//                        core_resetn is constant 1.
//
//   Ports:
//     aclk, aresetn      clock, synchronous active-low reset
//     s_axis (slave)     host -> block hash bytes, first byte is hash MSB
//     m_axis (master)    block -> host response: status, winner, password
//     hash               target hash to the manager (held during search)
//     start              search request, high for the whole search
//     core_resetn        active-low abort pulse to manager/cores
//     finish             manager done (level, stays high after a search)
//     result_password    password found, character 0 in bits [7:0]
//     winner_calculator  one-hot index of the winning core
//     busy               high in any state other than RX
// ---------------------------------------------------------------------------
module sha256_search_host_if #(
  parameter int          MAX_CHARACTERS = 12,
  parameter int          N_CALCULATORS  = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  sha256_search_host_if_if.slave        s_axis,
  sha256_search_host_if_if.master       m_axis,
  output logic [255:0]                  hash,
  output logic                          start,
  output logic                          core_resetn,
  input  logic                          finish,
  input  logic [MAX_CHARACTERS*8-1:0]   result_password,
  input  logic [N_CALCULATORS-1:0]      winner_calculator,
  output logic                          busy
);

  localparam int FRAME_LEN = MAX_CHARACTERS + 2;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  localparam logic [7:0] STATUS_FOUND   = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h02;

  // Reject configurations the response format cannot represent.
  if (N_CALCULATORS < 1 || N_CALCULATORS > 8 || MAX_CHARACTERS < 1 ||
      TIMEOUT_CYCLES == 32'd0) begin : g_bad_cfg
    $error("sha256_search_host_if: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_RX,
    ST_DRAIN,
    ST_SEARCH,
    ST_TX
  } state_t;

  state_t                    state_q;
  logic [4:0]                byte_cnt_q;
  logic [255:0]              hash_q;
  logic                      start_q;
  logic                      core_resetn_q;
  logic                      busy_q;
  logic                      s_tready_q;
  logic                      m_tvalid_q;
  logic                      m_tlast_q;
  logic [7:0]                m_tdata_q;
  logic [1:0]                guard_q;
  logic [7:0]                status_q;
  logic [7:0]                win_q;
  logic [MAX_CHARACTERS*8-1:0] pw_q;
  logic [IDX_W-1:0]          tx_idx_q;
  logic [IDX_W-1:0]          tx_idx_d;
  logic [7:0]                tx_byte_d;
  logic [7:0]                frame_bytes [FRAME_LEN];
  logic                      s_fire;
  logic                      m_fire;
  logic                      finish_ok;

`ifdef SEARCH_TIMEOUT_EN
  logic [31:0]               tmo_cnt_q;
`endif

  assign s_fire = s_axis.tvalid && s_tready_q;
  assign m_fire = m_tvalid_q && m_axis.tready;

  // finish is still high from the previous search when start rises, so it
  // only counts once the guard has seen three cycles of start.
  assign finish_ok = finish && (guard_q == 2'd3);

  // Response frame as a byte array: status, zero-extended winner, then the
  // password characters starting with result_password[7:0].
  assign frame_bytes[0] = status_q;
  assign frame_bytes[1] = win_q;
  genvar gi;
  for (gi = 0; gi < MAX_CHARACTERS; gi++) begin : g_pw_bytes
    assign frame_bytes[gi+2] = pw_q[gi*8 +: 8];
  end

  always_comb begin
    tx_idx_d  = tx_idx_q + 1'b1;
    tx_byte_d = 8'h00;
    if (tx_idx_d <= LAST_IDX) begin
      tx_byte_d = frame_bytes[tx_idx_d];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= ST_RX;
      byte_cnt_q    <= '0;
      hash_q        <= '0;
      start_q       <= 1'b0;
      core_resetn_q <= 1'b1;
      busy_q        <= 1'b0;
      s_tready_q    <= 1'b1;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tdata_q     <= '0;
      guard_q       <= '0;
      status_q      <= '0;
      win_q         <= '0;
      pw_q          <= '0;
      tx_idx_q      <= '0;
`ifdef SEARCH_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      // The abort pulse lasts a single cycle.
      core_resetn_q <= 1'b1;

      case (state_q)
        ST_RX: begin
          if (s_fire) begin
            // Byte k lands at hash[255-8k -: 8]; 255-8k == {31-k, 3'b111}.
            hash_q[{~byte_cnt_q, 3'b111} -: 8] <= s_axis.tdata;
            if (byte_cnt_q == 5'd31) begin
              byte_cnt_q <= '0;
              busy_q     <= 1'b1;
              if (s_axis.tlast) begin
                state_q    <= ST_SEARCH;
                start_q    <= 1'b1;
                s_tready_q <= 1'b0;
                guard_q    <= '0;
`ifdef SEARCH_TIMEOUT_EN
                tmo_cnt_q  <= '0;
`endif
              end else begin
                // Oversized frame: swallow the rest up to its tlast.
                state_q <= ST_DRAIN;
              end
            end else if (s_axis.tlast) begin
              // Short frame: dropped, partial hash content stays.
              byte_cnt_q <= '0;
            end else begin
              byte_cnt_q <= byte_cnt_q + 5'd1;
            end
          end
        end

        ST_DRAIN: begin
          if (s_fire && s_axis.tlast) begin
            state_q <= ST_RX;
            busy_q  <= 1'b0;
          end
        end

        ST_SEARCH: begin
          if (guard_q != 2'd3) begin
            guard_q <= guard_q + 2'd1;
          end
          if (finish_ok) begin
            pw_q       <= result_password;
            win_q      <= 8'(winner_calculator);
            status_q   <= STATUS_FOUND;
            start_q    <= 1'b0;
            state_q    <= ST_TX;
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= STATUS_FOUND;
            m_tlast_q  <= 1'b0;
            tx_idx_q   <= '0;
          end
`ifdef SEARCH_TIMEOUT_EN
          else if (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
            // Abort the cores and report a timeout with an empty result.
            pw_q          <= '0;
            win_q         <= '0;
            status_q      <= STATUS_TIMEOUT;
            start_q       <= 1'b0;
            core_resetn_q <= 1'b0;
            state_q       <= ST_TX;
            m_tvalid_q    <= 1'b1;
            m_tdata_q     <= STATUS_TIMEOUT;
            m_tlast_q     <= 1'b0;
            tx_idx_q      <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
          end
`endif
        end

        ST_TX: begin
          if (m_fire) begin
            if (tx_idx_q == LAST_IDX) begin
              m_tvalid_q <= 1'b0;
              m_tlast_q  <= 1'b0;
              state_q    <= ST_RX;
              s_tready_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              tx_idx_q  <= tx_idx_d;
              m_tdata_q <= tx_byte_d;
              m_tlast_q <= (tx_idx_d == LAST_IDX);
            end
          end
        end

        default: begin
          state_q <= ST_RX;
        end
      endcase
    end
  end

  assign s_axis.tready = s_tready_q;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tlast  = m_tlast_q;
  assign hash          = hash_q;
  assign start         = start_q;
  assign busy          = busy_q;

`ifdef SEARCH_TIMEOUT_EN
  assign core_resetn = core_resetn_q;
`else
  assign core_resetn = 1'b1;
  // The abort register only matters with the timeout; keep it referenced.
  logic unused_core_resetn;
  assign unused_core_resetn = core_resetn_q;
`endif

endmodule

// File: tb/tb_sha256_search_host_if.sv
// ---------------------------------------------------------------------------
// tb_sha256_search_host_if
//   Directed sequence with random hash bytes, passwords and winners, checked
//   against a frame-level model: the hash is the first 32 bytes of the last
//   frame, a response is {status, winner, password bytes LSB first}.
// ---------------------------------------------------------------------------
module tb_sha256_search_host_if;
  localparam int MAXC = 12;
  localparam int NC   = 4;
  localparam int FLEN = MAXC + 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  sha256_search_host_if_if s_bus ();
  sha256_search_host_if_if m_bus ();

  logic [255:0]      hash;
  logic              start;
  logic              core_resetn;
  logic              finish;
  logic [MAXC*8-1:0] result_password;
  logic [NC-1:0]     winner_calculator;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [255:0] hash_model;
  logic [7:0]   tx_frame[$];
  logic [7:0]   exp_resp[$];
  logic [3:0]   bp_pat = 4'b1001;   // m_tready per cycle: 1,0,0,1
  logic         start_before_last;
  int           frame_cycles;

  sha256_search_host_if #(
    .MAX_CHARACTERS(MAXC),
    .N_CALCULATORS (NC),
    .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .s_axis           (s_bus),
    .m_axis           (m_bus),
    .hash             (hash),
    .start            (start),
    .core_resetn      (core_resetn),
    .finish           (finish),
    .result_password  (result_password),
    .winner_calculator(winner_calculator),
    .busy             (busy)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic rand_frame(input int n);
    tx_frame.delete();
    for (int i = 0; i < n; i++) tx_frame.push_back(8'($urandom_range(0, 255)));
  endtask

  // Sends tx_frame with tlast on its final byte; updates the hash model.
  task automatic send_frame();
    int n;
    n = tx_frame.size();
    frame_cycles = 0;
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      s_bus.tdata  = tx_frame[i];
      s_bus.tvalid = 1'b1;
      s_bus.tlast  = (i == n - 1);
      while (!s_bus.tready && w < 200) begin
        tick();
        w++;
        frame_cycles++;
      end
      if (!s_bus.tready) begin
        check("s_tready_wait", {255'd0, s_bus.tready}, 256'd1);
        $fatal(1, "FAIL host byte never accepted");
      end
      if (i == n - 1) start_before_last = start;
      tick();
      frame_cycles++;
      if (i < 32) hash_model[255 - 8*i -: 8] = tx_frame[i];
    end
    s_bus.tvalid = 1'b0;
    s_bus.tlast  = 1'b0;
  endtask

  task automatic build_resp(input logic [7:0] status, input logic [NC-1:0] win,
                            input logic [MAXC*8-1:0] pw);
    exp_resp.delete();
    exp_resp.push_back(status);
    exp_resp.push_back(8'(win));
    for (int i = 0; i < MAXC; i++) exp_resp.push_back(pw[8*i +: 8]);
  endtask

  // Collects one response and compares it byte by byte with exp_resp.
  task automatic recv_response(input bit use_bp);
    int idx;
    int cyc;
    logic       stalled;
    logic [7:0] held_data;
    logic       held_last;
    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    while (idx < exp_resp.size() && cyc < 400) begin
      m_bus.tready = use_bp ? bp_pat[cyc % 4] : 1'b1;
      if (stalled && m_bus.tvalid) begin
        check("tx_stall_tdata", {248'd0, m_bus.tdata}, {248'd0, held_data});
        check("tx_stall_tlast", {255'd0, m_bus.tlast}, {255'd0, held_last});
      end
      if (m_bus.tvalid && m_bus.tready) begin
        check($sformatf("tx_byte%0d", idx), {248'd0, m_bus.tdata}, {248'd0, exp_resp[idx]});
        check($sformatf("tx_last%0d", idx), {255'd0, m_bus.tlast},
              {255'd0, (idx == exp_resp.size() - 1)});
        idx++;
        stalled = 1'b0;
      end else begin
        stalled   = m_bus.tvalid;
        held_data = m_bus.tdata;
        held_last = m_bus.tlast;
      end
      tick();
      cyc++;
    end
    m_bus.tready = 1'b0;
    check("tx_byte_count", 256'(idx), 256'(exp_resp.size()));
    check("tx_done_tvalid", {255'd0, m_bus.tvalid}, 256'd0);
    check("tx_done_s_tready", {255'd0, s_bus.tready}, 256'd1);
    check("tx_done_busy", {255'd0, busy}, 256'd0);
  endtask

  // Called right after the last hash byte was accepted.
  task automatic do_search(input int delay, input logic [MAXC*8-1:0] pw,
                           input logic [NC-1:0] win, input bit keep_finish, input bit use_bp);
    check("start_before_last", {255'd0, start_before_last}, 256'd0);
    check("start_latency", {255'd0, start}, 256'd1);
    check("hash_value", hash, hash_model);
    check("search_busy", {255'd0, busy}, 256'd1);
    check("search_s_tready", {255'd0, s_bus.tready}, 256'd0);
    repeat (delay) tick();
    check("search_no_tvalid", {255'd0, m_bus.tvalid}, 256'd0);
    check("search_start_held", {255'd0, start}, 256'd1);
    check("search_hash_held", hash, hash_model);
    check("core_resetn_idle", {255'd0, core_resetn}, 256'd1);
    finish = 1'b1;
    result_password = pw;
    winner_calculator = win;
    tick();
    check("start_drop", {255'd0, start}, 256'd0);
    if (!keep_finish) finish = 1'b0;
    build_resp(8'h01, win, pw);
    recv_response(use_bp);
  endtask

  initial begin
    logic [255:0]      sha_a;
    logic [MAXC*8-1:0] pw;
    logic [NC-1:0]     win;
    logic              seen;

    sha_a = 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
    s_bus.tdata = '0;
    s_bus.tvalid = 1'b0;
    s_bus.tlast = 1'b0;
    m_bus.tready = 1'b0;
    finish = 1'b0;
    result_password = '0;
    winner_calculator = '0;
    hash_model = '0;
    start_before_last = 1'b0;

    // Reset values.
    repeat (3) tick();
    check("rst_s_tready", {255'd0, s_bus.tready}, 256'd1);
    check("rst_m_tvalid", {255'd0, m_bus.tvalid}, 256'd0);
    check("rst_m_tlast", {255'd0, m_bus.tlast}, 256'd0);
    check("rst_m_tdata", {248'd0, m_bus.tdata}, 256'd0);
    check("rst_hash", hash, 256'd0);
    check("rst_start", {255'd0, start}, 256'd0);
    check("rst_core_resetn", {255'd0, core_resetn}, 256'd1);
    check("rst_busy", {255'd0, busy}, 256'd0);
    aresetn = 1'b1;
    tick();

    // SHA256("a"), then a found result after 50 cycles; finish left high.
    tx_frame.delete();
    for (int i = 0; i < 32; i++) tx_frame.push_back(sha_a[255 - 8*i -: 8]);
    send_frame();
    check("hash_sha_a", hash, sha_a);
    do_search(50, 96'h61, 4'b0010, 1'b1, 1'b0);

    // Stale finish: high for the first 3 start cycles, then a real finish.
    rand_frame(32);
    send_frame();
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (m_bus.tvalid) seen = 1'b1;
    end
    finish = 1'b0;
    repeat (20) begin
      tick();
      if (m_bus.tvalid) seen = 1'b1;
    end
    check("stale_finish_ignored", {255'd0, seen}, 256'd0);
    for (int i = 0; i < MAXC; i++) pw[8*i +: 8] = 8'($urandom_range(0, 255));
    win = NC'(1) << $urandom_range(0, NC - 1);
    do_search(0, pw, win, 1'b0, 1'b1);

    // Short frame: tlast on byte 10, dropped; partial hash content stays.
    rand_frame(11);
    send_frame();
    repeat (3) tick();
    check("short_no_start", {255'd0, start}, 256'd0);
    check("short_not_busy", {255'd0, busy}, 256'd0);
    check("short_partial_hash", hash, hash_model);
    rand_frame(32);
    send_frame();
    for (int i = 0; i < MAXC; i++) pw[8*i +: 8] = 8'($urandom_range(0, 255));
    win = NC'(1) << $urandom_range(0, NC - 1);
    do_search($urandom_range(3, 20), pw, win, 1'b0, 1'b1);

    // Long frame: 40 bytes, the tail is drained without back-pressure.
    rand_frame(40);
    send_frame();
    check("long_no_stall", 256'(frame_cycles), 256'd40);
    repeat (3) tick();
    check("long_no_start", {255'd0, start}, 256'd0);
    check("long_not_busy", {255'd0, busy}, 256'd0);
    check("long_hash", hash, hash_model);
    rand_frame(32);
    send_frame();
    for (int i = 0; i < MAXC; i++) pw[8*i +: 8] = 8'($urandom_range(0, 255));
    win = NC'(1) << $urandom_range(0, NC - 1);
    do_search($urandom_range(3, 20), pw, win, 1'b0, 1'b0);

`ifdef SEARCH_TIMEOUT_EN
    // Timeout: no finish; one-cycle abort after 100 search cycles.
    begin
      int lows;
      int first_low;
      rand_frame(32);
      send_frame();
      lows = 0;
      first_low = -1;
      for (int j = 1; j <= 150; j++) begin
        tick();
        if (!core_resetn) begin
          lows++;
          if (first_low < 0) begin
            first_low = j;
            check("timeout_start_low", {255'd0, start}, 256'd0);
          end
        end
      end
      check("timeout_pulse_len", 256'(lows), 256'd1);
      check("timeout_pulse_at", 256'(first_low), 256'd100);
      build_resp(8'h02, '0, '0);
      recv_response(1'b0);
    end
`endif

    // Reset in the middle of a search: no response afterwards.
    rand_frame(32);
    send_frame();
    repeat (5) tick();
    aresetn = 1'b0;
    tick();
    check("midrst_start", {255'd0, start}, 256'd0);
    check("midrst_busy", {255'd0, busy}, 256'd0);
    check("midrst_s_tready", {255'd0, s_bus.tready}, 256'd1);
    check("midrst_hash", hash, 256'd0);
    aresetn = 1'b1;
    m_bus.tready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (m_bus.tvalid) seen = 1'b1;
    end
    check("midrst_no_response", {255'd0, seen}, 256'd0);
    m_bus.tready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
